// File: rtl/divider_pkg.sv
// Shared types and constants for the parametrised divider: FSM states,
// latency helper and the fixed results for divide-by-zero / signed overflow.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } div_state_e;

    localparam int unsigned MAX_W = 64;

    // Special-case results, sliced down to WIDTH by the user.
    localparam logic [MAX_W-1:0] DIV0_QUOT = '1;
    localparam logic [MAX_W-1:0] OVF_REM   = '0;

    function automatic int unsigned LAT(input int unsigned w);
        return w + 2;
    endfunction

    // Most negative W-bit value; also the quotient of the signed-overflow case.
    function automatic logic [MAX_W-1:0] OVF_QUOT(input int unsigned w);
        logic [MAX_W-1:0] v;
        v        = '0;
        v[w-1]   = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/divider_param_if.sv
// Request/result bundle between the execute stage and the divider.
interface divider_param_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             busy;
    logic             data_resultRDY;
    logic [WIDTH-1:0] data_quotient;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;

    modport master (
        output start, is_signed, data_operandA, data_operandB,
        input  busy, data_resultRDY, data_quotient, data_remainder, data_exception
    );

    modport slave (
        input  start, is_signed, data_operandA, data_operandB,
        output busy, data_resultRDY, data_quotient, data_remainder, data_exception
    );
endinterface

// File: rtl/divider_step.sv
// One combinational non-restoring division step on the {A,Q} pair.
module divider_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH:0] a_sh;

    assign a_sh = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
    // Add/subtract choice uses the sign of A before the shift.
    assign a_o  = a_i[WIDTH] ? (a_sh + m_i) : (a_sh - m_i);
    assign q_o  = {q_i[WIDTH-2:0], ~a_o[WIDTH]};
endmodule

// File: rtl/divider_param.sv
// Iterative signed/unsigned non-restoring divider with start/busy handshake.
// Optional DIVIDER_EARLY_EXIT_EN skips the iterations when A=0 or B=0.
module divider_param
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic            clock,
    input logic            res,
    divider_param_if.slave bus
);
    localparam int unsigned      CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(OVF_QUOT(WIDTH));

    div_state_e       state_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH:0]   m_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] opa_q;
    logic [CW-1:0]    cnt_q;
    logic             negq_q, negr_q, div0_q, ovf_q;
    logic             busy_q, rdy_q, exc_q;
    logic [WIDTH-1:0] quot_q, rem_q;

    logic             sign_a, sign_b, skip_iter;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   step_a;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] quot_d, rem_d;

    assign sign_a = bus.is_signed & bus.data_operandA[WIDTH-1];
    assign sign_b = bus.is_signed & bus.data_operandB[WIDTH-1];
    assign abs_a  = sign_a ? -bus.data_operandA : bus.data_operandA;
    assign abs_b  = sign_b ? -bus.data_operandB : bus.data_operandB;

`ifdef DIVIDER_EARLY_EXIT_EN
    assign skip_iter = (bus.data_operandA == '0) || (bus.data_operandB == '0);
`else
    assign skip_iter = 1'b0;
`endif

    divider_step #(.WIDTH(WIDTH)) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (step_a),
        .q_o (step_q)
    );

    always_comb begin
        // Final restore only needs the low WIDTH bits: the result lies in [0, M).
        rem_mag = a_q[WIDTH] ? (a_q[WIDTH-1:0] + m_q[WIDTH-1:0]) : a_q[WIDTH-1:0];
        quot_d  = negq_q ? -q_q : q_q;
        rem_d   = negr_q ? -rem_mag : rem_mag;
        if (div0_q) begin
            quot_d = DIV0_QUOT[WIDTH-1:0];
            rem_d  = opa_q;
        end else if (ovf_q) begin
            quot_d = MIN_NEG;
            rem_d  = OVF_REM[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (res) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            opa_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            exc_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (bus.start) begin
                        a_q     <= '0;
                        q_q     <= abs_a;
                        m_q     <= {1'b0, abs_b};
                        opa_q   <= bus.data_operandA;
                        cnt_q   <= '0;
                        negq_q  <= sign_a ^ sign_b;
                        negr_q  <= sign_a;
                        div0_q  <= (bus.data_operandB == '0);
                        ovf_q   <= bus.is_signed && (bus.data_operandA == MIN_NEG)
                                   && (bus.data_operandB == '1);
                        busy_q  <= 1'b1;
                        state_q <= skip_iter ? FIX : ITER;
                    end
                end
                ITER: begin
                    a_q   <= step_a;
                    q_q   <= step_q;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quot_q  <= quot_d;
                    rem_q   <= rem_d;
                    exc_q   <= div0_q | ovf_q;
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.data_quotient  = quot_q;
    assign bus.data_remainder = rem_q;
    assign bus.data_exception = exc_q;
endmodule
